alu: RTL and testbench

Button-loaded arithmetic/logic unit for a board-level demo. Operand A, operand B and a 6-bit opcode are captured from a shared switch bus, each by its own push-button strobe. A combinational core computes the result and carry from the captured registers. Sits directly behind the board switches/buttons and drives the LEDs.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_core.sv | 43 ++++
 rtl/alu.sv | 77 +++++++
 tb/tb_alu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths and opcode encodings for the button-loaded demo ALU.
package alu_pkg;

  localparam int BUS_SIZE = 8;
  localparam int OP_SIZE  = 6;

  localparam logic [OP_SIZE-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_SIZE-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_SIZE-1:0] OP_AND = 6'b100100;
  localparam logic [OP_SIZE-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_SIZE-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_SIZE-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_SIZE-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_SIZE-1:0] OP_SRA = 6'b000011;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: (a, b, op) -> (result, carry/borrow).
module alu_core #(
  parameter int BUS_SIZE = alu_pkg::BUS_SIZE,
  parameter int OP_SIZE  = alu_pkg::OP_SIZE
) (
  input  logic [BUS_SIZE-1:0] a_i,
  input  logic [BUS_SIZE-1:0] b_i,
  input  logic [OP_SIZE-1:0]  op_i,
  output logic [BUS_SIZE-1:0] result_o,
  output logic                carry_o
);
  import alu_pkg::*;

  logic [BUS_SIZE:0] wideResult;

  // Add/sub run one bit wider so the top bit is the carry (or borrow for SUB).
  // Shifts use the full unsigned B, so oversized amounts flush to 0 / sign.
  always_comb begin
    wideResult = '0;
    result_o   = '0;
    carry_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        wideResult = {1'b0, a_i} + {1'b0, b_i};
        result_o   = wideResult[BUS_SIZE-1:0];
        carry_o    = wideResult[BUS_SIZE];
      end
      OP_SUB: begin
        wideResult = {1'b0, a_i} - {1'b0, b_i};
        result_o   = wideResult[BUS_SIZE-1:0];
        carry_o    = wideResult[BUS_SIZE];
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_SRL:  result_o = a_i >> b_i;
      OP_SRA:  result_o = $signed(a_i) >>> b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Switch/button-loaded ALU top. Define ALU_OUT_REG_EN to register o_ALUout/o_carry.
module alu #(
  parameter int BUS_SIZE = alu_pkg::BUS_SIZE,
  parameter int OP_SIZE  = alu_pkg::OP_SIZE
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [BUS_SIZE-1:0] i_swiches,
  input  logic                i_boton1,
  input  logic                i_boton2,
  input  logic                i_boton3,
  output logic [BUS_SIZE-1:0] o_ALUout,
  output logic                o_carry
);
  import alu_pkg::*;

  logic [BUS_SIZE-1:0] regA_q, regA_d;
  logic [BUS_SIZE-1:0] regB_q, regB_d;
  logic [OP_SIZE-1:0]  regOp_q, regOp_d;
  logic [BUS_SIZE-1:0] coreResult;
  logic                coreCarry;

  // Each strobe independently reloads its register from the shared bus.
  always_comb begin
    regA_d  = regA_q;
    regB_d  = regB_q;
    regOp_d = regOp_q;
    if (i_boton1) regA_d  = i_swiches;
    if (i_boton2) regB_d  = i_swiches;
    if (i_boton3) regOp_d = i_swiches[OP_SIZE-1:0];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      regA_q  <= '0;
      regB_q  <= '0;
      regOp_q <= '0;
    end else begin
      regA_q  <= regA_d;
      regB_q  <= regB_d;
      regOp_q <= regOp_d;
    end
  end

  alu_core #(
    .BUS_SIZE(BUS_SIZE),
    .OP_SIZE (OP_SIZE)
  ) u_core (
    .a_i     (regA_q),
    .b_i     (regB_q),
    .op_i    (regOp_q),
    .result_o(coreResult),
    .carry_o (coreCarry)
  );

`ifdef ALU_OUT_REG_EN
  logic [BUS_SIZE-1:0] aluOut_q;
  logic                carry_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      aluOut_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      aluOut_q <= coreResult;
      carry_q  <= coreCarry;
    end
  end

  assign o_ALUout = aluOut_q;
  assign o_carry  = carry_q;
`else
  assign o_ALUout = coreResult;
  assign o_carry  = coreCarry;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected results are queued on load and popped when the output is due.
module tb_alu;
  import alu_pkg::*;

  logic       i_clock;
  logic       i_reset;
  logic [7:0] i_swiches;
  logic       i_boton1;
  logic       i_boton2;
  logic       i_boton3;
  logic [7:0] o_ALUout;
  logic       o_carry;

  typedef struct {
    string      tag;
    logic [7:0] out;
    logic       carry;
  } expT;

  expT sb[$];
  int  checkCount = 0;
  int  failCount  = 0;

  alu dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_swiches(i_swiches),
    .i_boton1 (i_boton1),
    .i_boton2 (i_boton2),
    .i_boton3 (i_boton3),
    .o_ALUout (o_ALUout),
    .o_carry  (o_carry)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [7:0] out, input logic carry);
    expT e;
    e.tag   = tag;
    e.out   = out;
    e.carry = carry;
    sb.push_back(e);
  endtask

  // Called at the negedge right after the last load edge; registered outputs land one cycle later.
  task automatic checkResult();
    expT e;
`ifdef ALU_OUT_REG_EN
    @(negedge i_clock);
`endif
    e = sb.pop_front();
    checkOutput({e.tag, "_out"}, o_ALUout, e.out);
    checkOutput({e.tag, "_carry"}, {7'd0, o_carry}, {7'd0, e.carry});
  endtask

  task automatic loadReg(input int which, input logic [7:0] v);
    i_swiches = v;
    i_boton1  = (which == 1);
    i_boton2  = (which == 2);
    i_boton3  = (which == 3);
    @(negedge i_clock);
    i_boton1 = 1'b0;
    i_boton2 = 1'b0;
    i_boton3 = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [5:0] op, input logic [7:0] expOut, input logic expCarry);
    loadReg(1, a);
    loadReg(2, b);
    loadReg(3, {2'b00, op});
    pushExpect(tag, expOut, expCarry);
  endtask

  function automatic logic [8:0] modelAlu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int s;
    logic [7:0] r;
    r = 8'd0;
    s = 0;
    case (op)
      OP_ADD: begin
        s = int'(a) + int'(b);
        return {s[8], s[7:0]};
      end
      OP_SUB: begin
        s = int'(a) - int'(b);
        return {(a < b), s[7:0]};
      end
      OP_AND: for (int k = 0; k < 8; k++) r[k] = a[k] && b[k];
      OP_OR:  for (int k = 0; k < 8; k++) r[k] = a[k] || b[k];
      OP_XOR: for (int k = 0; k < 8; k++) r[k] = a[k] != b[k];
      OP_NOR: for (int k = 0; k < 8; k++) r[k] = !(a[k] || b[k]);
      default: r = 8'd0;
    endcase
    return {1'b0, r};
  endfunction

  initial begin
    logic [5:0] ops[6];
    logic [7:0] ra, rb;
    logic [5:0] rop;
    logic [8:0] m;

    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR};
    i_reset   = 1'b1;
    i_swiches = 8'd0;
    i_boton1  = 1'b0;
    i_boton2  = 1'b0;
    i_boton3  = 1'b0;
    repeat (2) @(negedge i_clock);
    pushExpect("reset", 8'd0, 1'b0);
    checkResult();
    i_reset = 1'b0;

    applyStimulus("add_ovf", 8'd255, 8'd2, OP_ADD, 8'd1, 1'b1);   checkResult();
    applyStimulus("sub", 8'd10, 8'd4, OP_SUB, 8'd6, 1'b0);        checkResult();
    applyStimulus("sub_borrow", 8'd10, 8'd12, OP_SUB, 8'd254, 1'b1); checkResult();
    applyStimulus("or", 8'h37, 8'h65, OP_OR, 8'h77, 1'b0);        checkResult();
    applyStimulus("xor", 8'h37, 8'h65, OP_XOR, 8'h52, 1'b0);      checkResult();
    applyStimulus("nor", 8'h37, 8'h65, OP_NOR, 8'h88, 1'b0);      checkResult();
    applyStimulus("srl2", 8'h80, 8'd2, OP_SRL, 8'h20, 1'b0);      checkResult();
    applyStimulus("sra2", 8'h80, 8'd2, OP_SRA, 8'hE0, 1'b0);      checkResult();
    applyStimulus("srl9", 8'h80, 8'd9, OP_SRL, 8'h00, 1'b0);      checkResult();
    applyStimulus("sra9", 8'h80, 8'd9, OP_SRA, 8'hFF, 1'b0);      checkResult();
    applyStimulus("sra_pos", 8'h40, 8'd3, OP_SRA, 8'h08, 1'b0);   checkResult();
    applyStimulus("bad_op", 8'hA5, 8'h5A, 6'b111111, 8'h00, 1'b0); checkResult();
    applyStimulus("and", 8'h37, 8'h65, OP_AND, 8'h25, 1'b0);      checkResult();

    // Reset with boton1 held: registers clear and A must not capture 0xFF.
    i_reset   = 1'b1;
    i_boton1  = 1'b1;
    i_swiches = 8'hFF;
    @(negedge i_clock);
    i_reset  = 1'b0;
    i_boton1 = 1'b0;
    pushExpect("mid_reset", 8'd0, 1'b0);
    checkResult();
    loadReg(2, 8'd1);
    loadReg(3, {2'b00, OP_ADD});
    pushExpect("post_reset_add", 8'd1, 1'b0);
    checkResult();

    i_swiches = 8'd7;
    i_boton1  = 1'b1;
    i_boton2  = 1'b1;
    @(negedge i_clock);
    i_boton1 = 1'b0;
    i_boton2 = 1'b0;
    loadReg(3, {2'b00, OP_ADD});
    pushExpect("dual_load", 8'd14, 1'b0);
    checkResult();

    for (int i = 0; i < 8; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = ops[$urandom_range(0, 5)];
      m   = modelAlu(ra, rb, rop);
      applyStimulus($sformatf("rand%0d", i), ra, rb, rop, m[7:0], m[8]);
      checkResult();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
